weight_fifo_arr_control: RTL
============================

Name: weight_fifo_arr_control

Overview:
Executes one weight-load request for a multiply. On a one-cycle `weight_fifo_arr_en` pulse it reads the weight submatrix row by row from weight memory and pushes every row into the weight FIFO array. Rows beyond the matrix height are zero-filled, so exactly `width_height` rows are pushed per request. Completion is reported to the multiply master on `weight_fifo_arr_done`.

Parameters:
- width_height, 16, systolic array dimension; rows pushed per request.
- addr_width, 8, weight memory address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- weight_fifo_arr_en  in  1  one-cycle start pulse from the multiply master.
- num_row_weight_mat  in  $clog2(width_height)  valid weight rows minus one; value N means N+1 rows (1..width_height).
- base_weight_addr  in  addr_width  memory address of row 0.
- fifo_stall  in  1  FIFO array almost full; blocks new row issue.
- weight_mem_addr  out  addr_width  read address.
- weight_mem_rd_en  out  1  read strobe; data returns the next cycle.
- fifo_wr_en  out  1  push one row into the FIFO array.
- fifo_zero_fill  out  1  qualifies fifo_wr_en; the pushed row is all zeros.
- fifo_row_idx  out  $clog2(width_height)  row index of the current push.
- busy  out  1  high in any state other than IDLE.
- weight_fifo_arr_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous, active-low. While reset = 0, the block goes to IDLE and all outputs are 0.
  - Reset mid-operation aborts the request; no done pulse is generated.
- State machine, 2-bit encoding.
  - IDLE → READ when `weight_fifo_arr_en` = 1 at a clock edge.
  - At that edge the block latches `num_row_weight_mat` and `base_weight_addr`, and clears the row counter.
  - `weight_fifo_arr_en` is ignored in every state except IDLE.
- READ, one row issued per cycle when `fifo_stall` = 0:
  - row < rows_valid: `weight_mem_rd_en` = 1 and `weight_mem_addr` = base + row, modulo 2^addr_width (wrap allowed).
  - row ≥ rows_valid: `weight_mem_rd_en` = 0 and the row is marked zero-fill.
  - When `fifo_stall` = 1: no issue, `weight_mem_rd_en` = 0, and the counter holds.
  - After the row width_height-1 issue, the next state is DRAIN.
- Write pipeline, 1-cycle latency:
  - `fifo_wr_en`, `fifo_zero_fill` and `fifo_row_idx` are the registered issue strobe, zero-fill flag and row index from the previous cycle.
  - An in-flight write always completes, even if `fifo_stall` rises. The FIFO array therefore asserts `fifo_stall` with at least one slot of margin.
- DRAIN: one cycle; the last write occurs here. Next state is DONE.
- DONE: `weight_fifo_arr_done` = 1 for exactly one cycle, then IDLE.
- Latency without stalls:
  - `weight_fifo_arr_en` sampled at edge 0.
  - Reads in cycles 1..width_height.
  - Writes in cycles 2..width_height+1.
  - Done in cycle width_height+2.
  - Each stall cycle adds one cycle.
- Boundaries:
  - N = width_height-1: no zero-fill rows.
  - N = 0: one read, then width_height-1 zero rows.
  - A new `weight_fifo_arr_en` arriving in the same cycle as DONE is ignored. It is accepted only in IDLE.
- Counter width: $clog2(width_height)+1, so the terminal count is detected without wrap.

Optional Feature:
- Macro: WFIFO_REVERSE_ORDER_EN.
- Defined: rows are issued from width_height-1 down to 0.
  - Zero-fill rows are issued first.
  - Read address = base + row for real rows, so memory order is unchanged.
  - `fifo_row_idx` counts down.
- Undefined: ascending order as described in Behaviour.
- Latency and handshake are identical in both modes.

Decomposition:
- Shared package holds:
  - state encodings IDLE = 2'b00, READ = 2'b01, DRAIN = 2'b10, DONE = 2'b11;
  - the row-index width function;
  - the default width_height.
- One natural sub-module, wfifo_row_issue: the row counter plus zero-fill compare, producing the issue strobe and index. The FSM and write pipeline stay in the top module.

Test Plan:
- Reset low mid-READ (row 5) → all outputs 0 immediately; IDLE; no done; the next en runs a full clean request.
- N = 15, base = 0x10, no stall, width_height = 16:
  - reads 0x10..0x1F in cycles 1..16;
  - 16 writes in cycles 2..17 with zero_fill = 0;
  - done in cycle 18 only.
- N = 2, base = 0x40:
  - 3 reads (0x40..0x42) with writes rows 0..2 zero_fill = 0;
  - rows 3..15 pushed with zero_fill = 1 and no rd_en;
  - done in cycle 18.
- base = 0xFE, N = 3 → read addresses 0xFE, 0xFF, 0x00, 0x01 (wrap).
- `fifo_stall` high for 3 cycles during row 7 → row 6 write still occurs; rd_en low for 3 cycles; done in cycle 21.
- Second en pulse while busy and in the DONE cycle → ignored; exactly one done pulse. With WFIFO_REVERSE_ORDER_EN and N = 1, `fifo_row_idx` runs 15..0, and the last two writes read base+1 then base.

Source files
------------

// File: rtl/weight_fifo_arr_control_pkg.sv
// Shared definitions for the weight FIFO array loader: FSM encodings, default
// geometry and the row-index width helper.
package weight_fifo_arr_control_pkg;

  localparam int WIDTH_HEIGHT_DEF = 16;
  localparam int ADDR_WIDTH_DEF   = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_READ  = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // Row-index width, never narrower than one bit.
  function automatic int row_idx_w(input int wh);
    return (wh > 1) ? $clog2(wh) : 1;
  endfunction

endpackage

// File: rtl/weight_fifo_arr_control_if.sv
// Bus between the multiply master / FIFO array / weight memory and the
// weight FIFO array loader.
interface weight_fifo_arr_control_if
  import weight_fifo_arr_control_pkg::*;
#(
  parameter int width_height = WIDTH_HEIGHT_DEF,
  parameter int addr_width   = ADDR_WIDTH_DEF
);
  localparam int RW = row_idx_w(width_height);

  logic                  weight_fifo_arr_en;
  logic [RW-1:0]         num_row_weight_mat;
  logic [addr_width-1:0] base_weight_addr;
  logic                  fifo_stall;
  logic [addr_width-1:0] weight_mem_addr;
  logic                  weight_mem_rd_en;
  logic                  fifo_wr_en;
  logic                  fifo_zero_fill;
  logic [RW-1:0]         fifo_row_idx;
  logic                  busy;
  logic                  weight_fifo_arr_done;

  modport master (
    output weight_fifo_arr_en, num_row_weight_mat, base_weight_addr, fifo_stall,
    input  weight_mem_addr, weight_mem_rd_en, fifo_wr_en, fifo_zero_fill,
           fifo_row_idx, busy, weight_fifo_arr_done
  );

  modport slave (
    input  weight_fifo_arr_en, num_row_weight_mat, base_weight_addr, fifo_stall,
    output weight_mem_addr, weight_mem_rd_en, fifo_wr_en, fifo_zero_fill,
           fifo_row_idx, busy, weight_fifo_arr_done
  );

endinterface

// File: rtl/weight_fifo_arr_control_row_issue.sv
// Row counter and zero-fill compare; WFIFO_REVERSE_ORDER_EN issues rows from
// the last index down to 0.
module wfifo_row_issue
  import weight_fifo_arr_control_pkg::*;
#(
  parameter int width_height = WIDTH_HEIGHT_DEF
)(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear_s,
  input  logic                                 active_s,
  input  logic                                 fifo_stall,
  input  logic [row_idx_w(width_height)-1:0]   num_row_r,
  output logic                                 issue_s,
  output logic                                 zero_s,
  output logic [row_idx_w(width_height)-1:0]   row_s,
  output logic                                 last_s
);
  localparam int RW = row_idx_w(width_height);
  localparam int CW = RW + 1;

  logic [CW-1:0] cnt_r;

  // Issue-slot counter: cleared on request accept, advances per issued row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (issue_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Map the slot count to a row index and flag rows past the matrix height.
  always_comb begin
    issue_s = active_s & ~fifo_stall;
    last_s  = (cnt_r == CW'(width_height - 1));
`ifdef WFIFO_REVERSE_ORDER_EN
    row_s   = RW'(width_height - 1) - cnt_r[RW-1:0];
`else
    row_s   = cnt_r[RW-1:0];
`endif
    zero_s  = (row_s > num_row_r);
  end

endmodule

// File: rtl/weight_fifo_arr_control.sv
// Weight FIFO array loader: reads a weight submatrix and pushes width_height
// rows (zero-filled beyond the matrix). Option macro: WFIFO_REVERSE_ORDER_EN.
module weight_fifo_arr_control
  import weight_fifo_arr_control_pkg::*;
#(
  parameter int width_height = WIDTH_HEIGHT_DEF,
  parameter int addr_width   = ADDR_WIDTH_DEF
)(
  input  logic                     clk,
  input  logic                     reset,
  weight_fifo_arr_control_if.slave bus
);
  localparam int RW = row_idx_w(width_height);

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [RW-1:0]         num_row_r;
  logic [addr_width-1:0] base_r;
  logic                  start_s;
  logic                  active_s;
  logic                  issue_s;
  logic                  zero_s;
  logic                  last_s;
  logic [RW-1:0]         row_s;
  logic                  rd_en_s;
  logic [addr_width-1:0] addr_s;
  logic                  wr_en_r;
  logic                  zero_r;
  logic [RW-1:0]         idx_r;

  assign start_s  = (state_r == ST_IDLE) & bus.weight_fifo_arr_en;
  assign active_s = (state_r == ST_READ);

  wfifo_row_issue #(.width_height(width_height)) u_row_issue (
    .clk        (clk),
    .reset      (reset),
    .clear_s    (start_s),
    .active_s   (active_s),
    .fifo_stall (bus.fifo_stall),
    .num_row_r  (num_row_r),
    .issue_s    (issue_s),
    .zero_s     (zero_s),
    .row_s      (row_s),
    .last_s     (last_s)
  );

  // Next-state logic; a start pulse is only honoured in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (bus.weight_fifo_arr_en) state_nxt_s = ST_READ;
                else                        state_nxt_s = ST_IDLE;
      ST_READ:  if (issue_s && last_s)      state_nxt_s = ST_DRAIN;
                else                        state_nxt_s = ST_READ;
      ST_DRAIN: state_nxt_s = ST_DONE;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Memory read strobe; address wraps modulo 2^addr_width.
  always_comb begin
    rd_en_s = issue_s & ~zero_s;
    if (rd_en_s) begin
      addr_s = base_r + addr_width'(row_s);
    end else begin
      addr_s = {addr_width{1'b0}};
    end
  end

  // FSM state and request parameters latched on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      num_row_r <= {RW{1'b0}};
      base_r    <= {addr_width{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (start_s) begin
        num_row_r <= bus.num_row_weight_mat;
        base_r    <= bus.base_weight_addr;
      end else begin
        num_row_r <= num_row_r;
        base_r    <= base_r;
      end
    end
  end

  // One-cycle write pipeline behind the issue stage; stall never cancels it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_r <= 1'b0;
      zero_r  <= 1'b0;
      idx_r   <= {RW{1'b0}};
    end else begin
      wr_en_r <= issue_s;
      zero_r  <= issue_s & zero_s;
      idx_r   <= issue_s ? row_s : {RW{1'b0}};
    end
  end

  assign bus.weight_mem_addr      = addr_s;
  assign bus.weight_mem_rd_en     = rd_en_s;
  assign bus.fifo_wr_en           = wr_en_r;
  assign bus.fifo_zero_fill       = zero_r;
  assign bus.fifo_row_idx         = idx_r;
  assign bus.busy                 = (state_r != ST_IDLE);
  assign bus.weight_fifo_arr_done = (state_r == ST_DONE);

endmodule
